// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_fifo
//  Purpose  : 8N1 UART receiver with a small receive FIFO. Bytes are
//             presented on a valid/ready stream. Stop-bit and overrun
//             errors are reported on sticky flags.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
   parameter int CLK_HZ     = 27000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rx,
   output logic [7:0]                    m_data,
   output logic                          m_valid,
   input  logic                          m_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr,
   output logic                          busy
);

   localparam int DIV   = CLK_HZ / BAUD;
   localparam int HALF  = DIV / 2;
   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic             rx_meta;
   logic             rx_s;
   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       idx;
   logic [7:0]       shreg;

   logic             start_tick;
   logic             bit_tick;
   logic             stop_tick;
   logic             push;
   logic             set_ovr;
   logic             set_ferr;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_inc;
   logic [LVL_W-1:0] level;
   logic             full;
   logic             pop;

   assign m_valid    = (level != '0);
   assign fifo_level = level;
   assign full       = (level == LVL_W'(FIFO_DEPTH));
   assign pop        = m_valid && m_ready;
   assign rd_ptr_inc = rd_ptr + PTR_W'(1);

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Receiver state register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; a stuck-low line after a bad stop bit parks in WAIT_HIGH.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (!rx_s)                state_nxt = S_START;
         S_START:     if (start_tick)           state_nxt = rx_s ? S_IDLE : S_DATA;
         S_DATA:      if (bit_tick && idx == 3'd7) state_nxt = S_STOP;
         S_STOP:      if (stop_tick)            state_nxt = rx_s ? S_IDLE : S_WAIT_HIGH;
         S_WAIT_HIGH: if (rx_s)                 state_nxt = S_IDLE;
         default:                               state_nxt = S_IDLE;
      endcase
   end

   // Sample strobes and stop-bit outcomes derived from state and baud counter.
   always_comb begin
      busy       = (state != S_IDLE);
      start_tick = (state == S_START) && (cnt == CNT_W'(HALF - 1));
      bit_tick   = (state == S_DATA)  && (cnt == CNT_W'(DIV - 1));
      stop_tick  = (state == S_STOP)  && (cnt == CNT_W'(DIV - 1));
      // A pop in the same cycle frees a slot, so a full FIFO still accepts.
      push       = stop_tick && rx_s && (!full || pop);
      set_ovr    = stop_tick && rx_s && full && !pop;
      set_ferr   = stop_tick && !rx_s;
   end

   // Baud counter, bit index and LSB-first shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else begin
         case (state)
            S_START: cnt <= start_tick ? '0 : cnt + CNT_W'(1);
            S_DATA: begin
               if (bit_tick) begin
                  cnt   <= '0;
                  idx   <= idx + 3'd1;
                  shreg <= {rx_s, shreg[7:1]};
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_STOP:  cnt <= stop_tick ? '0 : cnt + CNT_W'(1);
            default: begin
               cnt <= '0;
               idx <= '0;
            end
         endcase
      end
   end

   // FIFO storage; contents need no reset because level gates visibility.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   // FIFO pointers, level and registered head byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         m_data <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr_inc;
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
         // Keep m_data equal to the entry that will be at the head next cycle.
         if (pop) begin
            if (level > LVL_W'(1)) m_data <= mem[rd_ptr_inc];
            else if (push)         m_data <= shreg;
         end else if (push && level == '0) begin
            m_data <= shreg;
         end
      end
   end

   // Sticky error flags; a set event outranks a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (set_ferr)     frame_err <= 1'b1;
         else if (err_clr) frame_err <= 1'b0;
         if (set_ovr)      overrun   <= 1'b1;
         else if (err_clr) overrun   <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_fifo
//  Purpose  : Directed self-checking bench for uart_rx_fifo
//             (CLK_HZ=16, BAUD=1 -> 16 clocks per bit, FIFO_DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx;
   logic [7:0] m_data;
   logic       m_valid;
   logic       m_ready;
   logic [2:0] fifo_level;
   logic       frame_err;
   logic       overrun;
   logic       err_clr;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int c0;

   logic [7:0] pop_data [$];
   int         pop_cyc  [$];

   uart_rx_fifo #(
      .CLK_HZ     (16),
      .BAUD       (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .fifo_level (fifo_level),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .err_clr    (err_clr),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every accepted handshake with the cycle it happened in.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         pop_data.push_back(m_data);
         pop_cyc.push_back(cyc);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive one 8N1 frame; optionally raise m_ready only in the stop-sample cycle.
   task automatic send_frame(input logic [7:0] b, input int stop_cycles,
                             input logic stop_val, input logic ready_pulse);
      rx = 1'b0;
      wait_cyc(16);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(16);
      end
      rx = stop_val;
      if (ready_pulse) begin
         wait_cyc(10);
         m_ready = 1'b1;
         wait_cyc(1);
         m_ready = 1'b0;
         wait_cyc(stop_cycles - 11);
      end else begin
         wait_cyc(stop_cycles);
      end
      rx = 1'b1;
   endtask

   initial begin
      rst     = 1'b1;
      rx      = 1'b1;
      m_ready = 1'b0;
      err_clr = 1'b0;
      wait_cyc(3);
      chk("reset_m_valid",   {31'd0, m_valid},   32'd0);
      chk("reset_m_data",    {24'd0, m_data},    32'd0);
      chk("reset_level",     {29'd0, fifo_level}, 32'd0);
      chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
      chk("reset_overrun",   {31'd0, overrun},   32'd0);
      chk("reset_busy",      {31'd0, busy},      32'd0);
      rst = 1'b0;
      wait_cyc(5);

      // Single byte: first valid at start edge + 2 + 8 + 144 + 1.
      m_ready = 1'b1;
      pop_data.delete(); pop_cyc.delete();
      c0 = cyc;
      send_frame(8'hA5, 16, 1'b1, 1'b0);
      wait_cyc(5);
      chk("single_count",   pop_data.size(), 32'd1);
      chk("single_data",    {24'd0, pop_data[0]}, 32'hA5);
      chk("single_latency", pop_cyc[0] - c0, 32'd155);
      chk("single_ferr",    {31'd0, frame_err}, 32'd0);
      chk("single_ovr",     {31'd0, overrun}, 32'd0);
      chk("single_empty",   {31'd0, m_valid}, 32'd0);

      // Short low glitch: START sees high at the half-bit and gives up.
      pop_data.delete(); pop_cyc.delete();
      rx = 1'b0;
      wait_cyc(3);
      rx = 1'b1;
      wait_cyc(4);
      chk("glitch_busy_high", {31'd0, busy}, 32'd1);
      wait_cyc(10);
      chk("glitch_busy_low",  {31'd0, busy}, 32'd0);
      chk("glitch_no_push",   pop_data.size(), 32'd0);
      chk("glitch_ferr",      {31'd0, frame_err}, 32'd0);
      chk("glitch_ovr",       {31'd0, overrun}, 32'd0);

      // Framing error with stop held low, then a clean byte, then clear.
      send_frame(8'h3C, 40, 1'b0, 1'b0);
      chk("ferr_set",        {31'd0, frame_err}, 32'd1);
      chk("ferr_wait_high",  {31'd0, busy}, 32'd1);
      chk("ferr_no_push",    pop_data.size(), 32'd0);
      wait_cyc(4);
      chk("ferr_idle",       {31'd0, busy}, 32'd0);
      send_frame(8'h55, 16, 1'b1, 1'b0);
      wait_cyc(5);
      chk("ferr_next_count", pop_data.size(), 32'd1);
      chk("ferr_next_data",  {24'd0, pop_data[0]}, 32'h55);
      chk("ferr_sticky",     {31'd0, frame_err}, 32'd1);
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
      chk("ferr_cleared",    {31'd0, frame_err}, 32'd0);

      // Overrun: five back-to-back bytes into a four-entry FIFO.
      m_ready = 1'b0;
      pop_data.delete(); pop_cyc.delete();
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 16, 1'b1, 1'b0);
      chk("ovr_level",   {29'd0, fifo_level}, 32'd4);
      chk("ovr_flag",    {31'd0, overrun}, 32'd1);
      chk("ovr_head",    {24'd0, m_data}, 32'h01);
      m_ready = 1'b1;
      wait_cyc(6);
      m_ready = 1'b0;
      chk("ovr_drain_count", pop_data.size(), 32'd4);
      for (int i = 0; i < 4; i++) chk("ovr_drain_data", {24'd0, pop_data[i]}, 32'(i + 1));
      chk("ovr_drain_empty", {31'd0, m_valid}, 32'd0);
      chk("ovr_drain_level", {29'd0, fifo_level}, 32'd0);
      err_clr = 1'b1;
      wait_cyc(1);
      err_clr = 1'b0;
      chk("ovr_cleared", {31'd0, overrun}, 32'd0);

      // Full FIFO with a pop in the exact push cycle: byte is accepted.
      pop_data.delete(); pop_cyc.delete();
      send_frame(8'h11, 16, 1'b1, 1'b0);
      send_frame(8'h22, 16, 1'b1, 1'b0);
      send_frame(8'h33, 16, 1'b1, 1'b0);
      send_frame(8'h44, 16, 1'b1, 1'b0);
      chk("full_level", {29'd0, fifo_level}, 32'd4);
      send_frame(8'h55, 16, 1'b1, 1'b1);
      chk("simul_level", {29'd0, fifo_level}, 32'd4);
      chk("simul_ovr",   {31'd0, overrun}, 32'd0);
      chk("simul_head",  {24'd0, m_data}, 32'h22);
      m_ready = 1'b1;
      wait_cyc(6);
      chk("simul_count", pop_data.size(), 32'd5);
      chk("simul_d0", {24'd0, pop_data[0]}, 32'h11);
      chk("simul_d1", {24'd0, pop_data[1]}, 32'h22);
      chk("simul_d2", {24'd0, pop_data[2]}, 32'h33);
      chk("simul_d3", {24'd0, pop_data[3]}, 32'h44);
      chk("simul_d4", {24'd0, pop_data[4]}, 32'h55);

      // Stream ten bytes with continuous m_ready to exercise pointer wrap.
      pop_data.delete(); pop_cyc.delete();
      for (int i = 0; i < 10; i++) send_frame(8'(8'h03 + i * 8'h1D), 16, 1'b1, 1'b0);
      wait_cyc(5);
      chk("wrap_count", pop_data.size(), 32'd10);
      for (int i = 0; i < 10; i++) chk("wrap_data", {24'd0, pop_data[i]}, {24'd0, 8'(8'h03 + i * 8'h1D)});
      chk("wrap_level", {29'd0, fifo_level}, 32'd0);

      // Reset in the middle of data bit 4 with two bytes buffered.
      m_ready = 1'b0;
      pop_data.delete(); pop_cyc.delete();
      send_frame(8'hA1, 16, 1'b1, 1'b0);
      send_frame(8'hB2, 16, 1'b1, 1'b0);
      chk("pre_rst_level", {29'd0, fifo_level}, 32'd2);
      rx = 1'b0;
      wait_cyc(16);
      for (int i = 0; i < 4; i++) begin
         rx = (i == 1 || i == 3);
         wait_cyc(16);
      end
      rx = 1'b1;
      wait_cyc(8);
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      wait_cyc(1);
      rst = 1'b0;
      chk("rst_level", {29'd0, fifo_level}, 32'd0);
      chk("rst_valid", {31'd0, m_valid}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      wait_cyc(4);
      m_ready = 1'b1;
      send_frame(8'h7E, 16, 1'b1, 1'b0);
      wait_cyc(5);
      chk("post_rst_count", pop_data.size(), 32'd1);
      chk("post_rst_data",  {24'd0, pop_data[0]}, 32'h7E);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
